// File: rtl/clock_pkg.sv
// Shared constants, FSM state type and BCD helpers
// for the HH:MM:SS time-of-day counter.
package clock_pkg;

  localparam logic [7:0] BCD_MAX_SEC = 8'h59;
  localparam logic [7:0] BCD_MAX_MIN = 8'h59;
  localparam logic [7:0] BCD_MAX_H24 = 8'h23;
  localparam logic [7:0] BCD_MAX_H12 = 8'h12;

  localparam logic [1:0] ADJ_SS   = 2'd0;
  localparam logic [1:0] ADJ_MM   = 2'd1;
  localparam logic [1:0] ADJ_HH   = 2'd2;
  localparam logic [1:0] ADJ_NONE = 2'd3;

  typedef enum logic {
    RUN,
    CHECK
  } state_t;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v
  );
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic bcd_ok(
    input logic [7:0] v
  );
    return (v[7:4] <= 4'd9) &&
           (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD field counter: wraps MAX->MIN,
// with parallel load and a carry on wrap.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59,
  parameter logic [7:0] MIN = 8'h00,
  parameter logic [7:0] RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [7:0] ld_val,
  input  logic       inc,
  output logic [7:0] val,
  output logic       carry
);

  logic at_max;

  assign at_max = (val == MAX);
  assign carry  = inc && at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      val <= RST;
    end else if (ld) begin
      val <= ld_val;
    end else if (inc) begin
      val <= at_max ? MIN : bcd_inc(val);
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter with validated
// load handshake, field adjust and day wrap pulse.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter bit         H24    = 1'b1,
  parameter logic [7:0] RST_HH = 8'h00,
  parameter logic [7:0] RST_MM = 8'h00,
  parameter logic [7:0] RST_SS = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       load_pm,
  input  logic [1:0] adj_sel,
  input  logic       adj_inc,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       day_wrap,
  output logic       load_err
);

  localparam logic [7:0] HMAX =
    H24 ? BCD_MAX_H24 : BCD_MAX_H12;
  localparam logic [7:0] HMIN =
    H24 ? 8'h00 : 8'h01;

  state_t state, state_nxt;

  logic [7:0] cap_hh, cap_mm, cap_ss;
  logic       cap_pm;
  logic       hs, ok, hh_ok, commit;
  logic       adj, tk;
  logic       ss_inc, mm_inc, hh_inc;
  logic       ss_c, mm_c, hh_c;
  logic       ss_roll, mm_roll;
  logic       pm_flip, wrap;

  assign load_ready = (state == RUN);
  assign hs = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:   if (hs) state_nxt = CHECK;
      CHECK: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      cap_hh <= load_hh;
      cap_mm <= load_mm;
      cap_ss <= load_ss;
      cap_pm <= load_pm;
    end
  end

  // 12h mode has no hour zero
  assign hh_ok = H24 ?
    (cap_hh <= BCD_MAX_H24) :
    (cap_hh >= 8'h01 && cap_hh <= BCD_MAX_H12);

  assign ok = bcd_ok(cap_hh) &&
              bcd_ok(cap_mm) &&
              bcd_ok(cap_ss) &&
              (cap_mm <= BCD_MAX_MIN) &&
              (cap_ss <= BCD_MAX_SEC) &&
              hh_ok;

  assign commit = (state == CHECK) && ok;
  assign adj = !commit && adj_inc &&
               (adj_sel != ADJ_NONE);
  assign tk  = !commit && !adj && tick;

  assign ss_inc  = (adj && adj_sel == ADJ_SS) || tk;
  assign ss_roll = tk && ss_c;
  assign mm_inc  = (adj && adj_sel == ADJ_MM) || ss_roll;
  assign mm_roll = ss_roll && mm_c;
  assign hh_inc  = (adj && adj_sel == ADJ_HH) || mm_roll;

  bcd_mod_counter #(
    .MAX(BCD_MAX_SEC), .MIN(8'h00), .RST(RST_SS)
  ) u_ss (
    .clk(clk), .rst(rst), .ld(commit),
    .ld_val(cap_ss), .inc(ss_inc),
    .val(ss), .carry(ss_c)
  );

  bcd_mod_counter #(
    .MAX(BCD_MAX_MIN), .MIN(8'h00), .RST(RST_MM)
  ) u_mm (
    .clk(clk), .rst(rst), .ld(commit),
    .ld_val(cap_mm), .inc(mm_inc),
    .val(mm), .carry(mm_c)
  );

  bcd_mod_counter #(
    .MAX(HMAX), .MIN(HMIN), .RST(RST_HH)
  ) u_hh (
    .clk(clk), .rst(rst), .ld(commit),
    .ld_val(cap_hh), .inc(hh_inc),
    .val(hh), .carry(hh_c)
  );

  // only the tick chain moves pm, adjust never does
  assign pm_flip = !H24 && mm_roll && (hh == 8'h11);
  assign wrap = H24 ? (mm_roll && hh_c)
                    : (pm_flip && pm);

  always_ff @(posedge clk) begin
    if (rst) begin
      pm       <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      day_wrap <= wrap;
      load_err <= (state == CHECK) && !ok;
      if (commit) begin
        pm <= H24 ? 1'b0 : cap_pm;
      end else if (pm_flip) begin
        pm <= !pm;
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter in 24h
// and 12h configurations sharing one stimulus.
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       rst, tick, load_valid, load_pm;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [1:0] adj_sel;
  logic       adj_inc;

  logic       a_ready, a_pm, a_wrap, a_err;
  logic [7:0] a_hh, a_mm, a_ss;
  logic       b_ready, b_pm, b_wrap, b_err;
  logic [7:0] b_hh, b_mm, b_ss;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_time_counter #(.H24(1'b1)) dut24 (
    .clk(clk), .rst(rst), .tick(tick),
    .load_valid(load_valid), .load_ready(a_ready),
    .load_hh(load_hh), .load_mm(load_mm),
    .load_ss(load_ss), .load_pm(load_pm),
    .adj_sel(adj_sel), .adj_inc(adj_inc),
    .hh(a_hh), .mm(a_mm), .ss(a_ss), .pm(a_pm),
    .day_wrap(a_wrap), .load_err(a_err)
  );

  bcd_time_counter #(
    .H24(1'b0), .RST_HH(8'h12)
  ) dut12 (
    .clk(clk), .rst(rst), .tick(tick),
    .load_valid(load_valid), .load_ready(b_ready),
    .load_hh(load_hh), .load_mm(load_mm),
    .load_ss(load_ss), .load_pm(load_pm),
    .adj_sel(adj_sel), .adj_inc(adj_inc),
    .hh(b_hh), .mm(b_mm), .ss(b_ss), .pm(b_pm),
    .day_wrap(b_wrap), .load_err(b_err)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic t24(
    input string tag,
    input logic [23:0] exp
  );
    chk(tag, {8'h0, a_hh, a_mm, a_ss}, {8'h0, exp});
  endtask

  task automatic t12(
    input string tag,
    input logic [23:0] exp,
    input logic        p
  );
    chk(tag, {7'h0, b_pm, b_hh, b_mm, b_ss},
             {7'h0, p, exp});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_adj(input logic [1:0] sel);
    adj_sel = sel;
    adj_inc = 1'b1;
    step();
    adj_inc = 1'b0;
    adj_sel = 2'd3;
  endtask

  task automatic do_load(
    input logic [7:0] h,
    input logic [7:0] m,
    input logic [7:0] s,
    input logic       p
  );
    load_valid = 1'b1;
    load_hh = h;
    load_mm = m;
    load_ss = s;
    load_pm = p;
    step();
    load_valid = 1'b0;
    chk("ready_in_check", {31'h0, a_ready}, 32'h0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    load_valid = 1'b0;
    load_pm = 1'b0;
    load_hh = 8'h00;
    load_mm = 8'h00;
    load_ss = 8'h00;
    adj_sel = 2'd3;
    adj_inc = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    t24("reset_time24", 24'h000000);
    t12("reset_time12", 24'h120000, 1'b0);
    chk("reset_ready", {31'h0, a_ready}, 32'h1);
    chk("reset_err", {31'h0, a_err}, 32'h0);
    chk("reset_wrap", {31'h0, a_wrap}, 32'h0);

    repeat (3) do_tick();
    t24("three_ticks", 24'h000003);
    chk("ready_run", {31'h0, a_ready}, 32'h1);
    chk("err_run", {31'h0, a_err}, 32'h0);

    do_load(8'h23, 8'h59, 8'h58, 1'b0);
    t24("load_235958", 24'h235958);
    chk("load_ok_err", {31'h0, a_err}, 32'h0);
    do_tick();
    t24("tick_235959", 24'h235959);
    chk("wrap_before", {31'h0, a_wrap}, 32'h0);
    do_tick();
    t24("tick_midnight", 24'h000000);
    chk("wrap_pulse", {31'h0, a_wrap}, 32'h1);
    step();
    chk("wrap_one_cycle", {31'h0, a_wrap}, 32'h0);

    do_load(8'h12, 8'h34, 8'h5A, 1'b0);
    chk("bad_digit_err", {31'h0, a_err}, 32'h1);
    t24("bad_digit_time", 24'h000000);
    step();
    chk("err_one_cycle", {31'h0, a_err}, 32'h0);

    do_load(8'h24, 8'h00, 8'h00, 1'b0);
    chk("hour24_err", {31'h0, a_err}, 32'h1);
    t24("hour24_time", 24'h000000);
    step();

    do_load(8'h10, 8'h59, 8'h59, 1'b0);
    t24("load_105959", 24'h105959);
    do_adj(2'd1);
    t24("adj_mm_nocarry", 24'h100059);
    tick = 1'b1;
    do_adj(2'd0);
    tick = 1'b0;
    t24("adj_beats_tick", 24'h100000);
    tick = 1'b1;
    do_adj(2'd3);
    tick = 1'b0;
    t24("adj_none_tick", 24'h100001);

    do_load(8'h23, 8'h00, 8'h00, 1'b0);
    do_adj(2'd2);
    t24("adj_hh_wrap", 24'h000000);
    chk("adj_no_wrap", {31'h0, a_wrap}, 32'h0);

    do_load(8'h11, 8'h59, 8'h59, 1'b0);
    t12("load12_am", 24'h115959, 1'b0);
    do_tick();
    t12("noon_pm", 24'h120000, 1'b1);
    chk("noon_no_wrap", {31'h0, b_wrap}, 32'h0);
    t24("h24_noon", 24'h120000);
    chk("h24_pm_zero", {31'h0, a_pm}, 32'h0);

    do_load(8'h11, 8'h59, 8'h59, 1'b1);
    t12("load12_pm", 24'h115959, 1'b1);
    chk("h24_pm_ignored", {31'h0, a_pm}, 32'h0);
    do_tick();
    t12("midnight12", 24'h120000, 1'b0);
    chk("wrap12_pulse", {31'h0, b_wrap}, 32'h1);

    do_load(8'h12, 8'h59, 8'h59, 1'b0);
    do_tick();
    t12("twelve_to_one", 24'h010000, 1'b0);
    t24("h24_thirteen", 24'h130000);

    load_valid = 1'b1;
    load_hh = 8'h05;
    load_mm = 8'h06;
    load_ss = 8'h07;
    step();
    load_valid = 1'b0;
    chk("ready_before_rst", {31'h0, a_ready}, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    t24("rst_check_time", 24'h000000);
    t12("rst_check_t12", 24'h120000, 1'b0);
    chk("rst_check_err", {31'h0, a_err}, 32'h0);
    chk("rst_check_rdy", {31'h0, a_ready}, 32'h1);
    step();
    chk("rst_no_late_err", {31'h0, a_err}, 32'h0);
    t24("rst_discarded", 24'h000000);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
